// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave receiver.
//   spi_state_e : receive FSM encoding (idle / shifting a word)
//   SYNC_DEPTH  : number of flops in each pin synchroniser
package spi_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-bit flop-chain synchroniser with a clock enable.
// Each bit is resynchronised independently into the clk domain.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset, clears every stage to 0
//   en    : stages advance only while en=1
//   din   : asynchronous inputs
//   dout  : synchronised outputs (last stage of the chain)
module spi_sync
  import spi_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] stages;

  // Flop chain: stage 0 captures the pins, later stages follow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stages <= '0;
    end else if (en) begin
      stages <= {stages[SYNC_DEPTH-2:0], din};
    end
  end

  assign dout = stages[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_slave_gen.sv
// spi_slave_gen: oversampled SPI slave receiver with optional transmitter.
// All SPI pins are resynchronised into clk; the design advances only on
// clk edges where clk_half=0.
// Optional feature: define SPI_SLAVE_GEN_MISO_EN to build the miso
// transmit shifter; otherwise miso is tied to 0.
// Ports:
//   clk, reset      : system clock and synchronous active-low reset
//   clk_half        : qualifier, state advances only when 0
//   sck, cs, mosi   : asynchronous SPI pins (cs active-low)
//   miso            : serial transmit data
//   data, rdy       : last received word and its valid level
//   ack             : consumer acknowledge, clears rdy and overrun
//   overrun         : sticky flag, a word replaced an unacknowledged one
//   tx_data,tx_load : next word to transmit, latched while idle
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_half,
  input  logic             sck,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] data,
  output logic             rdy,
  input  logic             ack,
  output logic             overrun,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       pins_sync;
  logic             sck_s, cs_s, mosi_s;
  logic             sck_hist;
  logic             sck_norm, hist_norm;
  logic             lead, trail, sample, shift_edge;
  spi_state_e       state, state_next;
  logic             active;
  logic [CNT_W-1:0] bit_cnt, cnt_inc;
  logic             word_done;
  logic             done;
  logic [WIDTH-1:0] rx_shift, rx_next;

  assign en = ~clk_half;

  spi_sync #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .din   ({sck, cs, mosi}),
    .dout  (pins_sync)
  );

  assign sck_s  = pins_sync[2];
  assign cs_s   = pins_sync[1];
  assign mosi_s = pins_sync[0];

  // Normalising by CPOL makes "leading" always a 0->1 transition.
  assign sck_norm   = sck_s ^ CPOL;
  assign hist_norm  = sck_hist ^ CPOL;
  assign lead       = sck_norm & ~hist_norm;
  assign trail      = ~sck_norm & hist_norm;
  assign sample     = CPHA ? trail : lead;
  assign shift_edge = CPHA ? lead : trail;

  // A word is only shifted while selected; cs high in SHIFT aborts.
  assign active    = (state == ST_SHIFT) && !cs_s;
  assign cnt_inc   = bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign word_done = active && sample && (cnt_inc == CNT_W'(WIDTH));
  assign rx_next   = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_shift[WIDTH-1:1]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!cs_s) state_next = ST_SHIFT;
        else       state_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cs_s) state_next = ST_IDLE;
        else      state_next = ST_SHIFT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Receive datapath: sck history, bit counter, shift register, done flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_hist <= CPOL;
      bit_cnt  <= {CNT_W{1'b0}};
      rx_shift <= {WIDTH{1'b0}};
      done     <= 1'b0;
    end else if (en) begin
      sck_hist <= sck_s;
      done     <= word_done;
      if (!active) begin
        bit_cnt <= {CNT_W{1'b0}};
      end else if (sample) begin
        bit_cnt  <= word_done ? {CNT_W{1'b0}} : cnt_inc;
        rx_shift <= rx_next;
      end
    end
  end

  // Output words one cycle after completion; a completion wins over ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data    <= {WIDTH{1'b0}};
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end else if (en) begin
      if (done) begin
        data <= rx_shift;
        rdy  <= 1'b1;
      end else if (ack) begin
        rdy <= 1'b0;
      end
      if (ack) begin
        overrun <= 1'b0;
      end else if (done && rdy) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_GEN_MISO_EN
  logic [WIDTH-1:0] tx_latch, tx_shift;
  logic             miso_q;
  logic             tx_load_now, tx_step_now;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // A zero bit count on a non-sample edge means a word boundary, so the
  // next word starts there; CPHA=0 also needs its first bit at select.
  assign tx_load_now = ((!CPHA) && (state == ST_IDLE) && !cs_s) ||
                       (active && shift_edge && (bit_cnt == {CNT_W{1'b0}}));
  assign tx_step_now = active && shift_edge && (bit_cnt != {CNT_W{1'b0}});

  // Transmit latch and shifter driving the registered miso.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_latch <= {WIDTH{1'b0}};
      tx_shift <= {WIDTH{1'b0}};
      miso_q   <= 1'b0;
    end else if (en) begin
      if ((state == ST_IDLE) && tx_load) begin
        tx_latch <= tx_data;
      end
      if (tx_load_now) begin
        miso_q   <= first_bit(tx_latch);
        tx_shift <= advance(tx_latch);
      end else if (tx_step_now) begin
        miso_q   <= first_bit(tx_shift);
        tx_shift <= advance(tx_shift);
      end
    end
  end

  assign miso = miso_q;
`else
  logic unused_tx;

  assign unused_tx = ^{tx_data, tx_load, shift_edge};
  assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_gen.sv
// tb_spi_slave_gen: directed self-checking bench for spi_slave_gen.
// dut_a: WIDTH=8, mode 0, MSB first. dut_b: WIDTH=12, CPOL=1, CPHA=1, LSB first.
// Expected words are queued when sent and popped when rdy is observed.
module tb_spi_slave_gen;

  localparam int HB = 10;  // SPI half-bit period in clk cycles

  logic        clk, clk_half, reset;
  logic        sck_a, cs_a, mosi_a, miso_a, rdy_a, ack_a, overrun_a, tx_load_a;
  logic [7:0]  data_a, tx_data_a;
  logic        sck_b, cs_b, mosi_b, miso_b, rdy_b, ack_b, overrun_b, tx_load_b;
  logic [11:0] data_b, tx_data_b;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  miso_bits;
  logic        rdy_seen;

  spi_slave_gen #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .clk_half(clk_half),
    .sck(sck_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a),
    .data(data_a), .rdy(rdy_a), .ack(ack_a), .overrun(overrun_a),
    .tx_data(tx_data_a), .tx_load(tx_load_a)
  );

  spi_slave_gen #(.WIDTH(12), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .clk_half(clk_half),
    .sck(sck_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b),
    .data(data_b), .rdy(rdy_b), .ack(ack_b), .overrun(overrun_b),
    .tx_data(tx_data_b), .tx_load(tx_load_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial clk_half = 1'b0;
  always #10 clk_half = ~clk_half;  // flips on clk falling edges

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  task automatic wait_rdy_a();
    int n = 0;
    while (rdy_a !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check("rdy_a_wait", {31'd0, rdy_a}, 32'd1);
  endtask

  task automatic wait_rdy_b();
    int n = 0;
    while (rdy_b !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check("rdy_b_wait", {31'd0, rdy_b}, 32'd1);
  endtask

  task automatic ack_pulse_a();
    ack_a = 1'b1;
    tick(4);
    ack_a = 1'b0;
    tick(2);
  endtask

  // Mode-0 master: mosi set, half bit, sample miso, rise, half bit, fall.
  task automatic send_a(input logic [7:0] w, input int nbits, input bit lat);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi_a = w[i];
      tick(HB);
      miso_bits = {miso_bits[6:0], miso_a};
      if (rdy_a === 1'b1) rdy_seen = 1'b1;
      sck_a = 1'b1;
      if (lat && i == 0) begin
        for (int k = 1; k <= 4; k++) begin
          do @(posedge clk); while (clk_half !== 1'b0);
          #1;
          if (k == 3) check("rdy_lat_edge3", {31'd0, rdy_a}, 32'd0);
          if (k == 4) check("rdy_lat_edge4", {31'd0, rdy_a}, 32'd1);
        end
      end
      tick(HB);
      sck_a = 1'b0;
    end
  endtask

  // CPOL=1/CPHA=1 master, LSB first: fall + new mosi, half bit, rise.
  task automatic send_b(input logic [11:0] w);
    for (int i = 0; i < 12; i++) begin
      sck_b  = 1'b0;
      mosi_b = w[i];
      tick(HB);
      sck_b = 1'b1;
      tick(HB);
    end
  endtask

  initial begin
    reset = 1'b0;
    cs_a = 1'b1; sck_a = 1'b0; mosi_a = 1'b0; ack_a = 1'b0;
    tx_data_a = 8'h00; tx_load_a = 1'b0;
    cs_b = 1'b1; sck_b = 1'b1; mosi_b = 1'b0; ack_b = 1'b0;
    tx_data_b = 12'h000; tx_load_b = 1'b0;
    miso_bits = 8'h00; rdy_seen = 1'b0;
    tick(6);
    check("rst_data_a", {24'd0, data_a}, 32'd0);
    check("rst_rdy_a", {31'd0, rdy_a}, 32'd0);
    check("rst_ovr_a", {31'd0, overrun_a}, 32'd0);
    check("rst_miso_a", {31'd0, miso_a}, 32'd0);
    check("rst_data_b", {20'd0, data_b}, 32'd0);
    check("rst_rdy_b", {31'd0, rdy_b}, 32'd0);
    reset = 1'b1;
    tick(10);

    // Single word 0xA5 with rdy latency check and miso pattern.
    tx_data_a = 8'hC3; tx_load_a = 1'b1;
    tick(4);
    tx_load_a = 1'b0;
    tick(2);
    cs_a = 1'b0;
    tick(HB);
    exp_q.push_back(32'hA5);
    send_a(8'hA5, 8, 1'b1);
    wait_rdy_a();
    pop_check("data_A5", {24'd0, data_a});
    check("ovr_after_A5", {31'd0, overrun_a}, 32'd0);
`ifdef SPI_SLAVE_GEN_MISO_EN
    check("miso_seq", {24'd0, miso_bits}, 32'hC3);
`else
    check("miso_seq", {24'd0, miso_bits}, 32'h00);
`endif
    cs_a = 1'b1;
    tick(HB);
    ack_pulse_a();
    check("rdy_after_ack", {31'd0, rdy_a}, 32'd0);

    // Back-to-back 0x11, 0x22 with no ack -> overrun.
    cs_a = 1'b0;
    tick(HB);
    exp_q.push_back(32'h11);
    send_a(8'h11, 8, 1'b0);
    wait_rdy_a();
    pop_check("data_11", {24'd0, data_a});
    exp_q.push_back(32'h22);
    send_a(8'h22, 8, 1'b0);
    tick(HB);
    pop_check("data_22", {24'd0, data_a});
    check("ovr_set", {31'd0, overrun_a}, 32'd1);
    check("rdy_held", {31'd0, rdy_a}, 32'd1);
    cs_a = 1'b1;
    tick(HB);

    // ack only across a clk_half=1 edge must be ignored.
    do @(posedge clk); while (clk_half !== 1'b0);
    #1;
    ack_a = 1'b1;
    @(posedge clk);
    #1;
    ack_a = 1'b0;
    tick(4);
    check("rdy_ack_gated", {31'd0, rdy_a}, 32'd1);
    check("ovr_ack_gated", {31'd0, overrun_a}, 32'd1);
    ack_pulse_a();
    check("rdy_cleared", {31'd0, rdy_a}, 32'd0);
    check("ovr_cleared", {31'd0, overrun_a}, 32'd0);

    // Abort after 5 bits, then a full 0x5A word.
    rdy_seen = 1'b0;
    cs_a = 1'b0;
    tick(HB);
    send_a(8'hFF, 5, 1'b0);
    cs_a = 1'b1;
    tick(2 * HB);
    if (rdy_a === 1'b1) rdy_seen = 1'b1;
    check("data_kept_abort", {24'd0, data_a}, 32'h22);
    cs_a = 1'b0;
    tick(HB);
    exp_q.push_back(32'h5A);
    send_a(8'h5A, 8, 1'b0);
    check("no_rdy_abort", {31'd0, rdy_seen}, 32'd0);
    wait_rdy_a();
    pop_check("data_5A", {24'd0, data_a});
    cs_a = 1'b1;
    tick(HB);
    ack_pulse_a();

    // 12-bit CPOL=1 CPHA=1 LSB-first word.
    cs_b = 1'b0;
    tick(HB);
    exp_q.push_back(32'h3C7);
    send_b(12'h3C7);
    wait_rdy_b();
    pop_check("data_b_3C7", {20'd0, data_b});
    check("ovr_b", {31'd0, overrun_b}, 32'd0);
    cs_b = 1'b1;
    tick(HB);

    // Reset mid-word, then a full word.
    cs_a = 1'b0;
    tick(HB);
    send_a(8'hF0, 4, 1'b0);
    reset = 1'b0;
    cs_a = 1'b1;
    tick(6);
    check("mid_rst_data", {24'd0, data_a}, 32'd0);
    check("mid_rst_rdy", {31'd0, rdy_a}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun_a}, 32'd0);
    check("mid_rst_miso", {31'd0, miso_a}, 32'd0);
    reset = 1'b1;
    tick(10);
    check("post_rst_rdy", {31'd0, rdy_a}, 32'd0);
    cs_a = 1'b0;
    tick(HB);
    exp_q.push_back(32'h96);
    send_a(8'h96, 8, 1'b0);
    wait_rdy_a();
    pop_check("data_96", {24'd0, data_a});
    check("ovr_96", {31'd0, overrun_a}, 32'd0);
    cs_a = 1'b1;
    tick(HB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
